// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared state encoding, skid sizing and latency legality helpers
package fifo_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int MAX_RD_LATENCY = 3;

   function automatic int skid_depth(input int aw);
      return 1 << aw;
   endfunction

   // The skid buffer must cover every in-flight read plus one stalled beat.
   function automatic bit rd_latency_ok(input int lat, input int aw);
      return lat >= 0 && lat <= MAX_RD_LATENCY && skid_depth(aw) >= lat + 2;
   endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// stream_skid_buf: circular skid buffer absorbing FIFO read latency in front of a stream
//   i_clk, i_rstn   clock, async active-low reset
//   i_push          write i_push_data at the write pointer (caller guarantees room)
//   i_pop           consume the head word; ignored while empty
//   o_data          word at the registered read pointer
//   o_count         occupancy, 0..2**AW
module stream_skid_buf
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [AW:0]           o_count
);

   localparam int DEPTH = skid_depth(AW);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic                  pop_ok;

   assign pop_ok = i_pop && count != '0;

   // Pointers are AW bits wide so they wrap modulo DEPTH for free.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (i_push) begin
            mem[wr_ptr] <= i_push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, pop_ok};
      end
   end

   assign o_data  = mem[rd_ptr];
   assign o_count = count;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a synchronous FIFO and presents its words as a valid/ready stream
//   i_clk, i_rstn   clock, async active-low reset (drops in-flight reads)
//   i_en            drain enable
//   o_fifo_rd       FIFO read strobe
//   i_fifo_data     FIFO read data, valid RD_LATENCY edges after o_fifo_rd
//   i_fifo_empty    FIFO registered empty flag
//   o_tdata         stream data
//   o_tvalid        stream valid
//   i_tready        stream ready
//   o_count         skid buffer occupancy
//   o_busy          engine not idle
//   o_xfer_cnt      accepted stream beats, saturating
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 0,
   parameter int SKID_AW    = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_en,
   output logic                  o_fifo_rd,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_empty,
   output logic [DATA_WIDTH-1:0] o_tdata,
   output logic                  o_tvalid,
   input  logic                  i_tready,
   output logic [SKID_AW:0]      o_count,
   output logic                  o_busy,
   output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

   localparam int SKID_DEPTH = skid_depth(SKID_AW);
   localparam bit CFG_OK     = rd_latency_ok(RD_LATENCY, SKID_AW);

   if (!CFG_OK) begin : g_bad_cfg
      $error("fifo_stream_reader: RD_LATENCY must be 0..3 and 2**SKID_AW >= RD_LATENCY+2");
   end

   state_t      state;
   state_t      state_n;
   logic        push;
   logic [2:0]  inflight;
   logic [SKID_AW:0] occ;
   logic        drained;
   logic        beat;

   // Read-valid pipe: a 1 leaves the end exactly when the FIFO data for that read is present.
   if (RD_LATENCY == 0) begin : g_lat0
      assign push     = o_fifo_rd;
      assign inflight = '0;
   end else begin : g_latn
      logic [RD_LATENCY-1:0] pipe;
      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            pipe <= '0;
         end else begin
            pipe[0] <= o_fifo_rd;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
         end
      end
      assign push     = pipe[RD_LATENCY-1];
      assign inflight = 3'($countones(pipe));
   end

   stream_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (SKID_AW)
   ) u_skid (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_push      (push),
      .i_push_data (i_fifo_data),
      .i_pop       (beat),
      .o_data      (o_tdata),
      .o_count     (occ)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_n;
   end

   // Credits count buffered plus in-flight words and deliberately ignore a same-cycle pop,
   // so the strobe never depends on i_tready.
   always_comb begin
      drained   = occ == '0 && inflight == '0;
      o_fifo_rd = i_en && !i_fifo_empty && state != DRAIN
                  && (int'(occ) + int'(inflight) < SKID_DEPTH);
      state_n   = i_en ? RUN : (state == IDLE || drained) ? IDLE : DRAIN;
   end

   assign o_tvalid = occ != '0;
   assign o_count  = occ;
   assign o_busy   = state != IDLE;
   assign beat     = o_tvalid && i_tready;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)                          o_xfer_cnt <= '0;
      else if (beat && o_xfer_cnt != '1)    o_xfer_cnt <= o_xfer_cnt + 1'b1;
   end

endmodule
